// File: rtl/rom_arb_pkg.sv
// Shared types, constants and the address legality helper for the ROM access arbiter.
package rom_arb_pkg;

  localparam int PORT_F = 0;
  localparam int PORT_D = 1;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
  localparam int ADDR_MAX_W = 64;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } slot_word_t;

  // Word-aligned and inside the ROM; addr is zero-extended by the caller.
  function automatic logic addr_legal(input logic [ADDR_MAX_W-1:0] addr,
                                      input int unsigned words);
    logic [ADDR_MAX_W-1:0] idx;
    idx = addr >> 2;
    return (addr[1:0] == 2'b00) && (idx < {{(ADDR_MAX_W-32){1'b0}}, words});
  endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// One requester's request/response handshake bundle (fetch or data-load side).
interface rom_access_arbiter_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/rom_arb_resp_slot.sv
// One-entry valid/ready response holding register carrying a ROM word and an error flag.
module rom_arb_resp_slot
  import rom_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  slot_word_t  load_word,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        free
);

  // A full slot still counts as free when it is being drained this cycle.
  assign free = !resp_valid || resp_ready;

  // Capture on grant, otherwise drop valid once consumed; payload holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= 32'h00000000;
      resp_err   <= 1'b0;
    end else if (load) begin
      resp_valid <= 1'b1;
      resp_data  <= load_word.data;
      resp_err   <= load_word.err;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Two-port (fetch / data-load) arbiter in front of a combinational ROM with anti-starvation.
// Optional perf counters are compiled in when ROM_ARB_PERF_EN is defined.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_WORDS  = 100,
  parameter int ADDR_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_resp_valid,
  input  logic              f_resp_ready,
  output logic [31:0]       f_resp_data,
  output logic              f_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [31:0]       d_resp_data,
  output logic              d_resp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [15:0]       perf_conflicts,
  output logic [15:0]       perf_f_stalls
);

  logic       f_free;
  logic       d_free;
  logic       f_elig;
  logic       d_elig;
  logic [1:0] grant;
  logic [3:0] streak;
  logic       capture_legal;
  slot_word_t capture_word;

  // D normally wins a tie; F is forced through once D has won STREAK_MAX in a row.
  always_comb begin
    grant  = 2'b00;
    f_elig = rst_n && f_req_valid && f_free;
    d_elig = rst_n && d_req_valid && d_free;
    if (d_elig && (!f_elig || (streak != 4'(STREAK_MAX)))) begin
      grant[PORT_D] = 1'b1;
    end else if (f_elig) begin
      grant[PORT_F] = 1'b1;
    end else begin
      grant = 2'b00;
    end
  end

  assign f_req_ready = grant[PORT_F];
  assign d_req_ready = grant[PORT_D];
  assign rom_addr    = grant[PORT_D] ? d_req_addr : f_req_addr;

  // Illegal addresses never pass ROM data through.
  always_comb begin
    capture_legal = addr_legal(ADDR_MAX_W'(rom_addr), ROM_WORDS);
    if (capture_legal) begin
      capture_word.data = rom_data;
      capture_word.err  = 1'b0;
    end else begin
      capture_word.data = 32'h00000000;
      capture_word.err  = 1'b1;
    end
  end

  // Consecutive D wins while F waits; saturates at STREAK_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (!f_req_valid || grant[PORT_F]) begin
      streak <= 4'd0;
    end else if (grant[PORT_D] && (streak < 4'(STREAK_MAX))) begin
      streak <= streak + 4'd1;
    end else begin
      streak <= streak;
    end
  end

  rom_arb_resp_slot u_f_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant[PORT_F]),
    .load_word  (capture_word),
    .resp_ready (f_resp_ready),
    .resp_valid (f_resp_valid),
    .resp_data  (f_resp_data),
    .resp_err   (f_resp_err),
    .free       (f_free)
  );

  rom_arb_resp_slot u_d_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant[PORT_D]),
    .load_word  (capture_word),
    .resp_ready (d_resp_ready),
    .resp_valid (d_resp_valid),
    .resp_data  (d_resp_data),
    .resp_err   (d_resp_err),
    .free       (d_free)
  );

`ifdef ROM_ARB_PERF_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflicts <= 16'h0000;
      perf_f_stalls  <= 16'h0000;
    end else begin
      if (f_req_valid && d_req_valid && (perf_conflicts != 16'hFFFF)) begin
        perf_conflicts <= perf_conflicts + 16'h0001;
      end
      if (f_req_valid && !grant[PORT_F] && (perf_f_stalls != 16'hFFFF)) begin
        perf_f_stalls <= perf_f_stalls + 16'h0001;
      end
    end
  end
`else
  assign perf_conflicts = 16'h0000;
  assign perf_f_stalls  = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboard bench for rom_access_arbiter: reference model pushes expected responses, monitor pops.
module tb_rom_access_arbiter;
  import rom_arb_pkg::*;

  localparam int ROM_WORDS  = 100;
  localparam int ADDR_W     = 32;
  localparam int STREAK_MAX = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [15:0] perf_conflicts;
  logic [15:0] perf_f_stalls;
  logic [31:0] mem [ROM_WORDS];

  int n_cmp = 0;
  int n_fail = 0;
  exp_t qf[$];
  exp_t qd[$];
  int m_conf = 0;
  int m_stall = 0;

  rom_access_arbiter_if #(.ADDR_W(ADDR_W)) f_bus ();
  rom_access_arbiter_if #(.ADDR_W(ADDR_W)) d_bus ();

  rom_access_arbiter #(.ROM_WORDS(ROM_WORDS), .ADDR_W(ADDR_W), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_bus.req_valid), .f_req_ready(f_bus.req_ready), .f_req_addr(f_bus.req_addr),
    .f_resp_valid(f_bus.resp_valid), .f_resp_ready(f_bus.resp_ready),
    .f_resp_data(f_bus.resp_data), .f_resp_err(f_bus.resp_err),
    .d_req_valid(d_bus.req_valid), .d_req_ready(d_bus.req_ready), .d_req_addr(d_bus.req_addr),
    .d_resp_valid(d_bus.resp_valid), .d_resp_ready(d_bus.resp_ready),
    .d_resp_data(d_bus.resp_data), .d_resp_err(d_bus.resp_err),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .perf_conflicts(perf_conflicts), .perf_f_stalls(perf_f_stalls)
  );

  always #5 clk = ~clk;

  // Behavioural ROM; out-of-range reads return garbage the DUT must ignore.
  always_comb begin
    int idx;
    idx = int'(rom_addr >> 2);
    rom_data = (idx < ROM_WORDS) ? mem[idx] : 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_read(input logic [31:0] a);
    exp_t r;
    if ((a % 32'd4 == 32'd0) && ((a / 32'd4) < 32'(ROM_WORDS))) begin
      r.data = mem[int'(a / 32'd4)];
      r.err  = 1'b0;
    end else begin
      r.data = 32'h00000000;
      r.err  = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k < 6) return 32'($urandom_range(0, ROM_WORDS - 1)) << 2;
    else if (k == 6) return (32'($urandom_range(0, ROM_WORDS - 1)) << 2) + 32'($urandom_range(1, 3));
    else return 32'($urandom_range(ROM_WORDS, ROM_WORDS + 40)) << 2;
  endfunction

  task automatic drive(input logic fv, input logic [31:0] fa, input logic fr,
                       input logic dv, input logic [31:0] da, input logic dr);
    f_bus.req_valid  = fv;
    f_bus.req_addr   = fa;
    f_bus.resp_ready = fr;
    d_bus.req_valid  = dv;
    d_bus.req_addr   = da;
    d_bus.resp_ready = dr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: grant rules and slot occupancy derived from the arbitration rules.
  initial begin : model
    logic fv, dv, ef, ed, gf, gd, full_f, full_d;
    int run;
    full_f = 1'b0; full_d = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qf.delete(); qd.delete();
        full_f = 1'b0; full_d = 1'b0; run = 0;
        m_conf = 0; m_stall = 0;
      end else begin
        fv = f_bus.req_valid;
        dv = d_bus.req_valid;
        check("f_resp_valid", 32'(f_bus.resp_valid), 32'(full_f));
        check("d_resp_valid", 32'(d_bus.resp_valid), 32'(full_d));
        ef = fv && (!full_f || f_bus.resp_ready);
        ed = dv && (!full_d || d_bus.resp_ready);
        gd = ed && (!ef || (run != STREAK_MAX));
        gf = ef && !gd;
        check("f_req_ready", 32'(f_bus.req_ready), 32'(gf));
        check("d_req_ready", 32'(d_bus.req_ready), 32'(gd));
        check("rom_addr", rom_addr, gd ? d_bus.req_addr : f_bus.req_addr);
        if (gf) qf.push_back(ref_read(f_bus.req_addr));
        if (gd) qd.push_back(ref_read(d_bus.req_addr));
        if (fv && dv) m_conf++;
        if (fv && !gf) m_stall++;
        if (!fv || gf) run = 0;
        else if (gd && (run < STREAK_MAX)) run++;
        full_f = gf || (full_f && !f_bus.resp_ready);
        full_d = gd || (full_d && !d_bus.resp_ready);
      end
    end
  end

  // Monitor: compare every presented response against the queue head, pop on handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (f_bus.resp_valid) begin
          if (qf.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL f_resp_unexpected: got data %0h expected no response", f_bus.resp_data);
          end else begin
            check("f_resp_data", f_bus.resp_data, qf[0].data);
            check("f_resp_err", 32'(f_bus.resp_err), 32'(qf[0].err));
            if (f_bus.resp_ready) void'(qf.pop_front());
          end
        end
        if (d_bus.resp_valid) begin
          if (qd.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL d_resp_unexpected: got data %0h expected no response", d_bus.resp_data);
          end else begin
            check("d_resp_data", d_bus.resp_data, qd[0].data);
            check("d_resp_err", 32'(d_bus.resp_err), 32'(qd[0].err));
            if (d_bus.resp_ready) void'(qd.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [9:0]  exp_gd_seq;
    logic [31:0] addrs [3];
    logic        errs [3];
    exp_t        held;
    exp_t        nxt;

    for (int i = 0; i < ROM_WORDS; i++) mem[i] = $urandom();
    mem[2] = NOP_WORD;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

    repeat (3) next_cycle();
    check("rst_f_resp_valid", 32'(f_bus.resp_valid), 32'h0);
    check("rst_d_resp_data", d_bus.resp_data, 32'h0);
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // Contention: D x4 then forced F, twice.
    exp_gd_seq = 10'b0111101111;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_addr(), 1'b1, 1'b1, rand_addr(), 1'b1);
      @(negedge clk);
      check("contention_d_grant", 32'(d_bus.req_ready), 32'(exp_gd_seq[i]));
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
`ifdef ROM_ARB_PERF_EN
    check("perf_conflicts_10", 32'(perf_conflicts), 32'd10);
    check("perf_f_stalls_8", 32'(perf_f_stalls), 32'd8);
`else
    check("perf_conflicts_off", 32'(perf_conflicts), 32'd0);
    check("perf_f_stalls_off", 32'(perf_f_stalls), 32'd0);
`endif
    next_cycle();

    // Back-to-back fetches 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      if (i > 0) check("fetch_b2b_valid", 32'(f_bus.resp_valid), 32'h1);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("fetch_word2_valid", 32'(f_bus.resp_valid), 32'h1);
    check("fetch_word2_data", f_bus.resp_data, NOP_WORD);
    next_cycle();

    // Error handling on D: misaligned, out of range, last legal word.
    addrs[0] = 32'h6;   errs[0] = 1'b1;
    addrs[1] = 32'h190; errs[1] = 1'b1;
    addrs[2] = 32'h18C; errs[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, addrs[i], 1'b1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("d_err_case", 32'(d_bus.resp_err), 32'(errs[i]));
      check("d_err_data", d_bus.resp_data, errs[i] ? 32'h0 : mem[99]);
      next_cycle();
    end

    // Backpressure on F, then pass-through refill.
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
    next_cycle();
    held = ref_read(32'h10);
    nxt  = ref_read(32'h14);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("bp_f_req_ready", 32'(f_bus.req_ready), 32'h0);
      check("bp_f_resp_data_held", f_bus.resp_data, held.data);
      next_cycle();
    end
    drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("bp_refill_ready", 32'(f_bus.req_ready), 32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("bp_refill_valid", 32'(f_bus.resp_valid), 32'h1);
    check("bp_refill_data", f_bus.resp_data, nxt.data);
    next_cycle();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0);
      next_cycle();
    end

    // Reset mid-operation with a held F response.
    drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h24, 1'b0);
    repeat (2) next_cycle();
    @(negedge clk);
    check("pre_rst_f_valid", 32'(f_bus.resp_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_f_valid", 32'(f_bus.resp_valid), 32'h0);
    check("rst_async_d_valid", 32'(d_bus.resp_valid), 32'h0);
    check("rst_async_f_err", 32'(f_bus.resp_err), 32'h0);
    check("rst_async_f_data", f_bus.resp_data, 32'h0);
    check("rst_async_d_data", d_bus.resp_data, 32'h0);
    check("rst_async_f_ready", 32'(f_bus.req_ready), 32'h0);
    check("rst_async_d_ready", 32'(d_bus.req_ready), 32'h0);
    check("rst_async_perf", 32'(perf_conflicts), 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) next_cycle();
    @(negedge clk);
    check("drain_qf_empty", 32'(qf.size()), 32'h0);
    check("drain_qd_empty", 32'(qd.size()), 32'h0);
`ifdef ROM_ARB_PERF_EN
    check("perf_conflicts_model", 32'(perf_conflicts), 32'(m_conf));
    check("perf_f_stalls_model", 32'(perf_f_stalls), 32'(m_stall));
`else
    check("perf_conflicts_end", 32'(perf_conflicts), 32'h0);
    check("perf_f_stalls_end", 32'(perf_f_stalls), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
